// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel registered multiplexer with valid/ready handshaking.
// Selection is either a fixed externally chosen channel or a round-robin scan
// that starts just after the most recently served channel. The output is a
// single registered stream tagged with the index of the supplying channel.
module chan_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outCh;
  logic             r_outValid;
  logic             r_selErr;
  logic [SEL_W-1:0] r_rrPtr;

  logic             w_load;
  logic [N_CH-1:0]  w_grant;
  logic             w_grantAny;
  logic [SEL_W-1:0] w_grantIdx;
  logic [WIDTH-1:0] w_grantData;
  logic             w_selLegal;
  int               w_scanIdx;

  // The output register can take a new word when it is empty or being popped.
  assign w_load = !r_outValid || out_ready;

  // Choose at most one channel: the fixed select, or the first requester found
  // scanning upward from the channel after the last round-robin winner.
  always_comb begin
    w_grant     = '0;
    w_grantAny  = 1'b0;
    w_grantIdx  = '0;
    w_grantData = '0;
    w_selLegal  = 1'b0;
    w_scanIdx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        w_selLegal = 1'b1;
      end
    end
    if (!mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_grant[i]  = 1'b1;
          w_grantAny  = 1'b1;
          w_grantIdx  = SEL_W'(i);
          w_grantData = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        w_scanIdx = int'(r_rrPtr) + k;
        if (w_scanIdx >= N_CH) begin
          w_scanIdx = w_scanIdx - N_CH;
        end
        if (!w_grantAny && in_valid[w_scanIdx]) begin
          w_grant[w_scanIdx] = 1'b1;
          w_grantAny         = 1'b1;
          w_grantIdx         = SEL_W'(w_scanIdx);
          w_grantData        = in_data[w_scanIdx*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Accept is only offered to the granted channel, and never while in reset.
  assign in_ready = (rst_n && w_load) ? w_grant : '0;

  // Output register, round-robin pointer and the illegal-select flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_selErr   <= 1'b0;
      r_rrPtr    <= SEL_W'(N_CH - 1);
    end else begin
      r_selErr <= !mode && !w_selLegal;
      if (w_load) begin
        if (w_grantAny) begin
          r_outValid <= 1'b1;
          r_outData  <= w_grantData;
          r_outCh    <= w_grantIdx;
          if (mode) begin
            r_rrPtr <= w_grantIdx;
          end
        end else begin
          r_outValid <= 1'b0;
        end
      end
    end
  end

  assign out_data  = r_outData;
  assign out_ch    = r_outCh;
  assign out_valid = r_outValid;
  assign sel_err   = r_selErr;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Testbench for chan_mux_rr: a 4-channel instance exercises fixed select,
// round-robin fairness, backpressure, mode switching and mid-stream reset;
// a 3-channel instance exercises the out-of-range select. Expected words are
// queued when stimulus is issued and popped by a separate monitor process.
module tb_chan_mux_rr;

  logic        clk;
  logic        rst_n;

  logic [31:0] aInData;
  logic [3:0]  aInValid;
  logic [3:0]  aInReady;
  logic        aMode;
  logic [1:0]  aSel;
  logic [7:0]  aOutData;
  logic [1:0]  aOutCh;
  logic        aOutValid;
  logic        aOutReady;
  logic        aSelErr;

  logic [23:0] bInData;
  logic [2:0]  bInValid;
  logic [2:0]  bInReady;
  logic        bMode;
  logic [1:0]  bSel;
  logic [7:0]  bOutData;
  logic [1:0]  bOutCh;
  logic        bOutValid;
  logic        bOutReady;
  logic        bSelErr;

  int          total;
  int          bad;
  logic [11:0] aQ[$];
  logic [11:0] bQ[$];
  logic [3:0]  aCnt[4];
  logic [7:0]  heldData;

  chan_mux_rr #(.N_CH(4), .WIDTH(8)) dutA (
    .clk(clk), .rst_n(rst_n), .in_data(aInData), .in_valid(aInValid),
    .in_ready(aInReady), .mode(aMode), .sel(aSel), .out_data(aOutData),
    .out_ch(aOutCh), .out_valid(aOutValid), .out_ready(aOutReady),
    .sel_err(aSelErr)
  );

  chan_mux_rr #(.N_CH(3), .WIDTH(8)) dutB (
    .clk(clk), .rst_n(rst_n), .in_data(bInData), .in_valid(bInValid),
    .in_ready(bInReady), .mode(bMode), .sel(bSel), .out_data(bOutData),
    .out_ch(bOutCh), .out_valid(bOutValid), .out_ready(bOutReady),
    .sel_err(bSelErr)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // One cycle on the 4-channel instance: drive just after the rising edge,
  // queue the hand-chosen winner's word, then check in_ready mid-cycle.
  // Channel c carries data {c+1, per-channel counter}.
  task automatic applyStimulus(input logic rstN, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic r, input int expCh);
    logic [3:0] expReady;
    @(posedge clk); #1;
    rst_n     = rstN;
    aMode     = m;
    aSel      = s;
    aInValid  = v;
    aOutReady = r;
    for (int c = 0; c < 4; c++) begin
      aInData[c*8 +: 8] = {4'(c + 1), aCnt[c]};
    end
    expReady = '0;
    if (expCh >= 0) begin
      expReady[expCh] = 1'b1;
      aQ.push_back({4'(expCh), 4'(expCh + 1), aCnt[expCh]});
      aCnt[expCh] = aCnt[expCh] + 4'd1;
    end
    @(negedge clk);
    checkOutput("aInReady", 32'(aInReady), 32'(expReady));
  endtask

  // One cycle on the 3-channel instance in fixed mode.
  task automatic applyStimulusB(input logic [1:0] s, input logic [2:0] v, input int expCh);
    logic [2:0] expReady;
    @(posedge clk); #1;
    bSel     = s;
    bInValid = v;
    expReady = '0;
    if (expCh >= 0) begin
      expReady[expCh] = 1'b1;
      bQ.push_back({4'(expCh), bInData[expCh*8 +: 8]});
    end
    @(negedge clk);
    checkOutput("bInReady", 32'(bInReady), 32'(expReady));
  endtask

  // Monitor: every word the consumer accepts must match the queue head.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (aOutValid === 1'b1 && aOutReady === 1'b1) begin
        if (aQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL aScoreboard: got ch=%0d data=0x%0h expected no word", aOutCh, aOutData);
        end else begin
          e = aQ.pop_front();
          checkOutput("aScoreboard", 32'({4'(aOutCh), aOutData}), 32'(e));
        end
      end
      if (bOutValid === 1'b1 && bOutReady === 1'b1) begin
        if (bQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL bScoreboard: got ch=%0d data=0x%0h expected no word", bOutCh, bOutData);
        end else begin
          e = bQ.pop_front();
          checkOutput("bScoreboard", 32'({4'(bOutCh), bOutData}), 32'(e));
        end
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    aInData   = '0;
    aInValid  = 4'hF;
    aMode     = 1'b1;
    aSel      = 2'd0;
    aOutReady = 1'b1;
    bInData   = {8'hC2, 8'hB1, 8'hA0};
    bInValid  = 3'b111;
    bMode     = 1'b0;
    bSel      = 2'd0;
    bOutReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      aCnt[c] = 4'(c + 1);
    end

    // Reset held with every channel requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstInReady", 32'(aInReady), 32'h0);
      checkOutput("rstOutValid", 32'(aOutValid), 32'h0);
      checkOutput("rstOutData", 32'(aOutData), 32'h0);
      checkOutput("rstOutCh", 32'(aOutCh), 32'h0);
      checkOutput("rstSelErr", 32'(aSelErr), 32'h0);
      checkOutput("rstInReadyB", 32'(bInReady), 32'h0);
    end
    bInValid = 3'b000;

    // Fixed mode stepping sel 0..3.
    applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 2'd1, 4'hF, 1'b1, 1);
    checkOutput("fixedData0", 32'(aOutData), 32'h11);
    applyStimulus(1'b1, 1'b0, 2'd2, 4'hF, 1'b1, 2);
    checkOutput("fixedData1", 32'(aOutData), 32'h22);
    applyStimulus(1'b1, 1'b0, 2'd3, 4'hF, 1'b1, 3);
    checkOutput("fixedData2", 32'(aOutData), 32'h33);
    checkOutput("fixedCh2", 32'(aOutCh), 32'h2);
    applyStimulus(1'b1, 1'b0, 2'd3, 4'h0, 1'b1, -1);
    checkOutput("fixedData3", 32'(aOutData), 32'h44);
    checkOutput("fixedCh3", 32'(aOutCh), 32'h3);
    checkOutput("aSelErrPow2", 32'(aSelErr), 32'h0);

    // Round-robin with all channels requesting, then only ch1 and ch3.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, i % 4);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, (i % 2 == 0) ? 1 : 3);
    end

    // Backpressure after a ch0 transfer.
    heldData = {4'd1, aCnt[0]};
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, -1);
      checkOutput("bpHoldValid", 32'(aOutValid), 32'h1);
      checkOutput("bpHoldCh", 32'(aOutCh), 32'h0);
      checkOutput("bpHoldData", 32'(aOutData), 32'(heldData));
    end
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, -1);

    // Round-robin wins ch2, two fixed ch0 transfers, then round-robin resumes at ch3.
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0100, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, -1);

    // Reset while a word is held: the word is discarded, first grant is ch0.
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'hF, 1'b0, -1);
    checkOutput("preRstValid", 32'(aOutValid), 32'h1);
    void'(aQ.pop_back());
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 0);
    checkOutput("postRstValid", 32'(aOutValid), 32'h0);
    checkOutput("postRstData", 32'(aOutData), 32'h0);
    checkOutput("postRstCh", 32'(aOutCh), 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, -1);
    checkOutput("postRstWordCh", 32'(aOutCh), 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, -1);
    checkOutput("idleValid", 32'(aOutValid), 32'h0);

    // Three-channel instance: legal select, then sel=3 held for three cycles.
    applyStimulusB(2'd1, 3'b111, 1);
    checkOutput("bSelErrLegal", 32'(bSelErr), 32'h0);
    applyStimulusB(2'd3, 3'b111, -1);
    checkOutput("bWordValid", 32'(bOutValid), 32'h1);
    checkOutput("bSelErr0", 32'(bSelErr), 32'h0);
    applyStimulusB(2'd3, 3'b111, -1);
    checkOutput("bIllegalValid1", 32'(bOutValid), 32'h0);
    checkOutput("bSelErr1", 32'(bSelErr), 32'h1);
    applyStimulusB(2'd3, 3'b111, -1);
    checkOutput("bIllegalValid2", 32'(bOutValid), 32'h0);
    checkOutput("bSelErr2", 32'(bSelErr), 32'h1);
    applyStimulusB(2'd0, 3'b000, -1);
    checkOutput("bSelErr3", 32'(bSelErr), 32'h1);
    applyStimulusB(2'd0, 3'b000, -1);
    checkOutput("bSelErrClear", 32'(bSelErr), 32'h0);

    repeat (2) @(negedge clk);
    checkOutput("aQueueDrained", 32'(aQ.size()), 32'h0);
    checkOutput("bQueueDrained", 32'(bQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised N-channel registered multiplexer with valid/ready handshaking and two selection modes: fixed (externally selected channel) and round-robin (automatic fair scan of all requesting channels). It generalises the team's combinational 4:1 mux into a streaming block that arbitrates between N data sources and presents one registered output stream with a channel tag. It sits between multiple producer channels and a single downstream consumer.

## Interface
Parameters:
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel in bits
- SEL_W, $clog2(N_CH), channel index width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel data valid
- in_ready  out  N_CH  per-channel accept; at most one bit high in any cycle
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used in fixed mode
- out_data  out  WIDTH  registered output data
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output register holds valid data
- out_ready  in  1  downstream accept
- sel_err  out  1  registered one-cycle pulse: fixed mode with sel >= N_CH

## Operation
- Output register load enable: load = !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - mode=0: grant channel sel if sel < N_CH and in_valid[sel]; otherwise none.
  - mode=1: scan starting at rr_ptr+1, wrapping at N_CH-1 -> 0; grant the first channel with in_valid set; none if in_valid is all zero.
- in_ready[i] = load && grant[i]. Transfer on channel i when in_valid[i] && in_ready[i].
- On transfer: out_data <= channel data, out_ch <= i, out_valid <= 1. In mode=1 only, rr_ptr <= i.
- On load with no grant: out_valid <= 0; out_data and out_ch hold their previous values.
- out_valid && !out_ready: out_data, out_ch, out_valid held stable; all in_ready low.
- rr_ptr is not updated in fixed mode; it keeps its last round-robin value for when mode returns to 1.
- mode or sel changes take effect on the next grant evaluation; data already held in the output register is unaffected.
- sel_err <= (mode==0 && sel >= N_CH); it is evaluated every cycle, independent of load. It is always 0 when N_CH is a power of two.

## Timing
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=N_CH-1, so the first round-robin grant checks ch0 first. in_ready is all-zero during reset cycles.
- Latency: one cycle from input transfer to out_valid/out_data.
- Throughput: one transfer per cycle while out_ready=1.
- in_ready depends combinationally on out_ready, in_valid, mode, and sel. There is no combinational path from any input to out_data or out_valid.
- Asserting reset mid-stream discards the held output word. No partial state survives.
- Simultaneous events:
  - A downstream pop and a new transfer in the same cycle: the output is replaced with no bubble.
  - A downstream pop with no grant: out_valid falls the next cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, and in_ready=0 in every reset cycle.
- Fixed mode, N_CH=4, WIDTH=8, out_ready=1: data ch0..3 = 0x11,0x22,0x33,0x44, all valid. Step sel 0->3, one sel per cycle -> the next cycle shows out_data 0x11,0x22,0x33,0x44 with out_ch 0..3, and only in_ready[sel] high.
- Round-robin fairness: mode=1, all channels continuously valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,… for 16 cycles. With only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure: mode=1, out_ready=0 for 4 cycles after the first transfer -> out_data/out_ch frozen, in_ready=0. When out_ready returns to 1 -> the next channel in scan order is transferred, with no word lost or duplicated. Check this with a scoreboard on an incrementing per-channel counter.
- Boundary and illegal select: N_CH=3, mode=0, sel=3, in_valid=3'b111 -> no in_ready, out_valid falls to 0, and sel_err pulses each cycle sel=3 is held.
- Mode switch and reset mid-operation:
  - Round-robin grants ch2, then switch to mode=0, sel=0 for 2 transfers, then back to mode=1 -> the next grant is ch3.
  - Assert rst_n=0 while out_valid=1 -> out_valid=0 the next cycle, and the first grant after reset is ch0.
